// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state type and helpers for sequential adders
package adder_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} adder_state_t;

  // Digit counter width; a single-digit operation still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ripple_digit_adder.sv
// rtl/ripple_digit_adder.sv - combinational ripple chain of DIGIT full adders
module ripple_digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic w_c;

  always_comb begin
    s     = '0;
    w_c   = ci;
    c_msb = ci;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = w_c;
      s[i] = x[i] ^ y[i] ^ w_c;
      w_c  = (x[i] & y[i]) | (w_c & (x[i] ^ y[i]));
    end
    co = w_c;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - multi-cycle adder, DIGIT bits per clock, valid/ready on both sides
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 2,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("digit_serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate

  adder_state_t      r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [DIGIT-1:0]  w_s;
  logic              w_co;
  logic              w_c_msb;
  logic [WIDTH-1:0]  w_sacc_next;
  logic              w_final_ovf;

  ripple_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (r_a[DIGIT-1:0]),
    .y     (r_b[DIGIT-1:0]),
    .ci    (r_carry),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_c_msb)
  );

  // The partial-sum register holds only the earlier digits; the final digit
  // comes straight from the adder so the result loads with no bubble cycle.
  generate
    if (N == 1) begin : g_single
      assign w_sacc_next = w_s;
    end else begin : g_multi
      logic [WIDTH-DIGIT-1:0] r_sacc;
      assign w_sacc_next = {w_s, r_sacc};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sacc <= '0;
        end else if (r_state == S_CALC) begin
          r_sacc <= w_sacc_next[WIDTH-1:DIGIT];
        end
      end
    end
  endgenerate

  assign w_final_ovf = (SIGNED != 0) ? (w_c_msb ^ w_co) : w_co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_sum   <= w_sacc_next;
            r_cout  <= w_co;
            r_ovf   <= w_final_ovf;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - self-checking bench for digit_serial_adder
module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 8-bit pair (unsigned and signed flag) sharing all inputs
  logic       iv8, or8, cin8;
  logic [7:0] a8, b8;
  logic       ir_u, ov_u, cout_u, ovf_u;
  logic       ir_s, ov_s, cout_s, ovf_s;
  logic [7:0] sum_u, sum_s;

  digit_serial_adder #(.WIDTH(8), .DIGIT(2), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir_u), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov_u), .out_ready(or8), .sum(sum_u), .cout(cout_u), .ovf(ovf_u));

  digit_serial_adder #(.WIDTH(8), .DIGIT(2), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir_s), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov_s), .out_ready(or8), .sum(sum_s), .cout(cout_s), .ovf(ovf_s));

  // 4-bit instances with DIGIT = 1, 2, 4
  logic       iv4, cin4;
  logic [3:0] a4, b4;
  logic       or4 [3];
  logic       ir4 [3];
  logic       ov4 [3];
  logic       co4 [3];
  logic       of4 [3];
  logic [3:0] sum4 [3];

  for (genvar g = 0; g < 3; g++) begin : g_w4
    localparam int D = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    digit_serial_adder #(.WIDTH(4), .DIGIT(D), .SIGNED(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4[g]), .a(a4), .b(b4), .cin(cin4),
      .out_valid(ov4[g]), .out_ready(or4[g]), .sum(sum4[g]), .cout(co4[g]), .ovf(of4[g]));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] s, output logic co, output logic os);
    int t;
    int st;
    t  = int'(a) + int'(b) + int'(c);
    s  = t[7:0];
    co = t[8];
    st = int'($signed(a)) + int'($signed(b)) + int'(c);
    os = (st > 127) || (st < -128);
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (!(ir_u && ir_s) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'd0, ir_u && ir_s}, 32'd1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input int hold, input bit pulse);
    logic [7:0] es;
    logic       ec, eos;
    int         lat;
    model8(a, b, c, es, ec, eos);
    wait_idle8();
    a8 = a; b8 = b; cin8 = c; iv8 = 1'b1; or8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    chk("busy_in_ready", {31'd0, ir_u}, 32'd0);
    lat = 0;
    while (!ov_u && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 32'd4);
    chk("sum_u", {24'd0, sum_u}, {24'd0, es});
    chk("cout_u", {31'd0, cout_u}, {31'd0, ec});
    chk("ovf_u", {31'd0, ovf_u}, {31'd0, ec});
    chk("valid_s", {31'd0, ov_s}, 32'd1);
    chk("sum_s", {24'd0, sum_s}, {24'd0, es});
    chk("cout_s", {31'd0, cout_s}, {31'd0, ec});
    chk("ovf_s", {31'd0, ovf_s}, {31'd0, eos});
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        iv8 = 1'(i & 1); a8 = 8'($urandom); b8 = 8'($urandom);
      end
      @(negedge clk);
      chk("hold_valid", {31'd0, ov_u}, 32'd1);
      chk("hold_sum", {24'd0, sum_u}, {24'd0, es});
      chk("hold_in_ready", {31'd0, ir_u}, 32'd0);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk("release_valid", {31'd0, ov_u}, 32'd0);
    chk("release_in_ready", {31'd0, ir_u}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] sum;
    logic       cout, ovf_u, ovf_s;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [7:0] rs;
    logic       rc, ro;
    logic [4:0] t4;
    bit         done [3];
    int         n;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0; iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    for (int g = 0; g < 3; g++) or4[g] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, ir_u}, 32'd1);
    chk("rst_out_valid", {31'd0, ov_u}, 32'd0);
    chk("rst_sum", {24'd0, sum_u}, 32'd0);
    chk("rst_cout", {31'd0, cout_u}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_s}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors: constants checked directly, then through the handshake task.
    for (int i = 0; i < 7; i++) begin
      model8(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, ro);
      chk("table_model_sum", {24'd0, rs}, {24'd0, vecs[i].sum});
      chk("table_model_flags", {29'd0, rc, rc, ro}, {29'd0, vecs[i].cout, vecs[i].ovf_u, vecs[i].ovf_s});
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, i % 3, 1'b0);
    end

    // Backpressure with in_valid pulses while the result waits.
    run8(8'h3C, 8'h4B, 1'b1, 5, 1'b1);

    // Reset mid-calculation discards the operation.
    run8(8'h12, 8'h34, 1'b0, 0, 1'b0);
    wait_idle8();
    a8 = 8'h55; b8 = 8'h55; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_hold_sum", {24'd0, sum_u}, 32'h46);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, ov_u}, 32'd0);
    chk("abort_sum", {24'd0, sum_u}, 32'd0);
    chk("abort_in_ready", {31'd0, ir_u}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run8(8'h01, 8'h02, 1'b0, 1, 1'b0);

    for (int i = 0; i < 40; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));

    // Exhaustive 4-bit sweep with random downstream stalls.
    for (int k = 0; k < 512; k++) begin
      n = 0;
      while (!(ir4[0] && ir4[1] && ir4[2]) && n < 50) begin
        @(negedge clk);
        n++;
      end
      a4 = 4'(k); b4 = 4'(k >> 4); cin4 = 1'(k >> 8);
      t4 = 5'(a4) + 5'(b4) + 5'(cin4);
      iv4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv4 = 1'b0;
      for (int g = 0; g < 3; g++) done[g] = 1'b0;
      n = 0;
      while (n < 60) begin
        for (int g = 0; g < 3; g++) begin
          if (ov4[g] && !done[g]) begin
            chk("sweep_sum", {28'd0, sum4[g]}, {28'd0, t4[3:0]});
            chk("sweep_cout", {31'd0, co4[g]}, {31'd0, t4[4]});
            chk("sweep_ovf", {31'd0, of4[g]}, {31'd0, t4[4]});
            done[g] = 1'b1;
          end
          or4[g] = 1'($urandom);
        end
        if (done[0] && done[1] && done[2] && ir4[0] && ir4[1] && ir4[2]) break;
        @(negedge clk);
        n++;
      end
      if (n >= 60) chk("sweep_timeout", n, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
